// File: rtl/cnet_req_arbiter.sv
// cnet_req_arbiter
// Shares the CPCI->CNET register request path between port A (PCI register
// access) and port B (DMA/statistics poller). One request is granted at a
// time with round-robin tie-breaking. At most one read is outstanding, and
// its return is routed back to the port that issued it.
//
// Optional feature: define CNET_ARB_TIMEOUT_EN to abort a read that gets no
// n2p_rd_rdy within TIMEOUT cycles of its grant. The abort is reported as
// rd_err with 32'hDEAD_BEEF data.
module cnet_req_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 27,
  parameter int TIMEOUT    = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_gnt,
  output logic                  a_rd_vld,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  output logic                  a_rd_err,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_gnt,
  output logic                  b_rd_vld,
  output logic [DATA_WIDTH-1:0] b_rd_data,
  output logic                  b_rd_err,
  output logic                  p2n_req,
  output logic                  p2n_we,
  output logic [ADDR_WIDTH-1:0] p2n_addr,
  output logic [DATA_WIDTH-1:0] p2n_data,
  input  logic                  p2n_full,
  input  logic [DATA_WIDTH-1:0] n2p_data,
  input  logic                  n2p_rd_rdy,
  input  logic                  cnet_reprog
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;

  localparam logic [DATA_WIDTH-1:0] RD_ABORT_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

  logic [1:0]            state_r;
  logic                  last_b_r;   // 1: the most recent grant went to port B
  logic                  owner_b_r;  // 1: the outstanding read belongs to port B
  logic                  grant_s;
  logic                  win_b_s;
  logic                  rd_done_s;
  logic                  rd_err_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  timeout_hit_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

`ifdef CNET_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_r;

  // Count cycles spent in WAIT_RD. The count is 0 in the grant cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_r <= 16'd0;
    end else if (state_r != ST_WAIT_RD) begin
      tmo_cnt_r <= 16'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end
  end

  assign timeout_hit_s = (tmo_cnt_r == 16'(TIMEOUT - 1));
`else
  // No counter in this build, so WAIT_RD only exits on a return, a reprogram
  // or a reset. This term is constant-false for every legal TIMEOUT.
  assign timeout_hit_s = (TIMEOUT == 32'sd0);
`endif

  // Payload of the selected requester, forwarded to the CNET FIFO on a grant.
  assign sel_we_s   = win_b_s ? b_we   : a_we;
  assign sel_addr_s = win_b_s ? b_addr : a_addr;
  assign sel_data_s = win_b_s ? b_data : a_data;

  // Arbitration decision in IDLE, and read completion decision in WAIT_RD.
  always_comb begin
    grant_s   = 1'b0;
    win_b_s   = 1'b0;
    rd_done_s = 1'b0;
    rd_err_s  = 1'b0;
    rd_data_s = n2p_data;
    case (state_r)
      ST_IDLE: begin
        if ((a_req || b_req) && !p2n_full && !cnet_reprog) begin
          grant_s = 1'b1;
          // B wins when it is alone, or when both request and A went last.
          win_b_s = b_req && (!a_req || !last_b_r);
        end else begin
          grant_s = 1'b0;
          win_b_s = 1'b0;
        end
      end
      ST_WAIT_RD: begin
        // A reprogram beats a return, and a return beats a timeout.
        if (cnet_reprog || (!n2p_rd_rdy && timeout_hit_s)) begin
          rd_done_s = 1'b1;
          rd_err_s  = 1'b1;
          rd_data_s = RD_ABORT_DATA;
        end else if (n2p_rd_rdy) begin
          rd_done_s = 1'b1;
          rd_err_s  = 1'b0;
        end else begin
          rd_done_s = 1'b0;
          rd_err_s  = 1'b0;
        end
      end
      default: begin
        grant_s = 1'b0;
      end
    endcase
  end

  // State, round-robin pointer, read owner and every registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      last_b_r  <= 1'b1;
      owner_b_r <= 1'b0;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      p2n_req   <= 1'b0;
      p2n_we    <= 1'b0;
      p2n_addr  <= {ADDR_WIDTH{1'b0}};
      p2n_data  <= {DATA_WIDTH{1'b0}};
      a_rd_vld  <= 1'b0;
      b_rd_vld  <= 1'b0;
      a_rd_err  <= 1'b0;
      b_rd_err  <= 1'b0;
      a_rd_data <= {DATA_WIDTH{1'b0}};
      b_rd_data <= {DATA_WIDTH{1'b0}};
    end else begin
      // Strobes and the request payload last one cycle. rd_data holds its value.
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      p2n_req  <= 1'b0;
      p2n_we   <= 1'b0;
      p2n_addr <= {ADDR_WIDTH{1'b0}};
      p2n_data <= {DATA_WIDTH{1'b0}};
      a_rd_vld <= 1'b0;
      b_rd_vld <= 1'b0;
      a_rd_err <= 1'b0;
      b_rd_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            last_b_r  <= win_b_s;
            owner_b_r <= win_b_s;
            a_gnt     <= !win_b_s;
            b_gnt     <= win_b_s;
            p2n_req   <= 1'b1;
            p2n_we    <= sel_we_s;
            p2n_addr  <= sel_addr_s;
            p2n_data  <= sel_data_s;
            state_r   <= sel_we_s ? ST_HOLD : ST_WAIT_RD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // One idle cycle lets p2n_full and the requester settle.
          state_r <= ST_IDLE;
        end
        ST_WAIT_RD: begin
          if (rd_done_s) begin
            if (owner_b_r) begin
              b_rd_vld  <= 1'b1;
              b_rd_err  <= rd_err_s;
              b_rd_data <= rd_data_s;
            end else begin
              a_rd_vld  <= 1'b1;
              a_rd_err  <= rd_err_s;
              a_rd_data <= rd_data_s;
            end
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_RD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnet_req_arbiter.sv
// Directed testbench for cnet_req_arbiter. Expected output events (grants
// and read returns, stamped with their cycle) are queued as stimulus is
// driven. A negedge monitor pops one entry for each observed or overdue event.
module tb_cnet_req_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 27;
  localparam int TMO   = 16;
  localparam int OBS_W = 4 + AW + DW + 4 + 2 * DW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_gnt, b_gnt, a_rd_vld, b_rd_vld, a_rd_err, b_rd_err;
  logic [DW-1:0] a_rd_data, b_rd_data;
  logic          p2n_req, p2n_we, p2n_full;
  logic [AW-1:0] p2n_addr;
  logic [DW-1:0] p2n_data, n2p_data;
  logic          n2p_rd_rdy, cnet_reprog;

  cnet_req_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
    .a_gnt(a_gnt), .a_rd_vld(a_rd_vld), .a_rd_data(a_rd_data), .a_rd_err(a_rd_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
    .b_gnt(b_gnt), .b_rd_vld(b_rd_vld), .b_rd_data(b_rd_data), .b_rd_err(b_rd_err),
    .p2n_req(p2n_req), .p2n_we(p2n_we), .p2n_addr(p2n_addr), .p2n_data(p2n_data),
    .p2n_full(p2n_full), .n2p_data(n2p_data), .n2p_rd_rdy(n2p_rd_rdy),
    .cnet_reprog(cnet_reprog)
  );

  always #5 clk = ~clk;

  logic [OBS_W-1:0] obs_s;
  assign obs_s = {a_gnt, b_gnt, p2n_req, p2n_we, p2n_addr, p2n_data,
                  a_rd_vld, b_rd_vld, a_rd_err, b_rd_err, a_rd_data, b_rd_data};

  typedef struct {
    int               cyc;
    logic [OBS_W-1:0] vec;
    string            tag;
  } ev_t;

  ev_t           exp_q[$];
  logic [DW-1:0] mdl_a_rd = 32'h0;
  logic [DW-1:0] mdl_b_rd = 32'h0;
  int            cyc      = 0;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected grant: one gnt pulse plus the winner's payload on p2n.
  function void exp_gnt(int c, bit pb, bit we, logic [AW-1:0] ad, logic [DW-1:0] d, string tag);
    ev_t e;
    e.cyc = c;
    e.tag = tag;
    e.vec = {!pb, pb, 1'b1, we, ad, d, 4'b0000, mdl_a_rd, mdl_b_rd};
    exp_q.push_back(e);
  endfunction

  // Expected read return: update the model's held read data for that port.
  function void exp_rd(int c, bit pb, bit err, logic [DW-1:0] d, string tag);
    ev_t e;
    if (pb) mdl_b_rd = d;
    else    mdl_a_rd = d;
    e.cyc = c;
    e.tag = tag;
    e.vec = {4'b0000, {AW{1'b0}}, {DW{1'b0}}, !pb, pb, err & !pb, err & pb, mdl_a_rd, mdl_b_rd};
    exp_q.push_back(e);
  endfunction

  ev_t  mon_e;
  logic mon_ev;

  // Compare every observed event, and every event that is due, against the queue head.
  always @(negedge clk) begin
    mon_ev = a_gnt | b_gnt | p2n_req | a_rd_vld | b_rd_vld;
    if (mon_ev || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
      end else begin
        mon_e.cyc = -1;
        mon_e.vec = '0;
        mon_e.tag = "unexpected_event";
      end
      n_checks++;
      assert (mon_ev && mon_e.cyc == cyc && obs_s === mon_e.vec) begin
        n_pass++;
      end else begin
        $error("FAIL %s: event=%0b at cycle %0d obs=%h, expected cycle %0d vec=%h",
               mon_e.tag, mon_ev, cyc, obs_s, mon_e.cyc, mon_e.vec);
      end
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [OBS_W-1:0] o, input logic [OBS_W-1:0] x);
    n_checks++;
    assert (o === x) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %h, expected %h", tag, o, x);
    end
  endtask

  initial begin
    reset_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_data = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_data = '0;
    p2n_full = 1'b0; n2p_data = '0; n2p_rd_rdy = 1'b0; cnet_reprog = 1'b0;
    tick(3);
    chk("reset_outputs", obs_s, '0);
    reset_n = 1'b1;
    tick(2);

    // A back-to-back writes, then B wins a tie because A went last.
    n = cyc;
    a_req = 1'b1; a_we = 1'b1; a_addr = 27'h100; a_data = 32'h1234_5678;
    exp_gnt(n + 1, 1'b0, 1'b1, 27'h100, 32'h1234_5678, "a_wr_first");
    tick(1);
    a_addr = 27'h104; a_data = 32'h9ABC_DEF0;
    exp_gnt(n + 3, 1'b0, 1'b1, 27'h104, 32'h9ABC_DEF0, "a_wr_spacing");
    tick(2);
    a_addr = 27'h108; a_data = 32'h0F0F_0F0F;
    b_req = 1'b1; b_we = 1'b1; b_addr = 27'h200; b_data = 32'h55AA_55AA;
    exp_gnt(n + 5, 1'b1, 1'b1, 27'h200, 32'h55AA_55AA, "b_wins_tie");
    tick(2);
    b_req = 1'b0;
    exp_gnt(n + 7, 1'b0, 1'b1, 27'h108, 32'h0F0F_0F0F, "a_after_b");
    tick(2);
    a_req = 1'b0;
    tick(1);

    // p2n_full blocks the grant, and the grant follows the cycle after full drops.
    n = cyc;
    p2n_full = 1'b1; a_req = 1'b1; a_we = 1'b0; a_addr = 27'h300; a_data = 32'h0;
    tick(3);
    p2n_full = 1'b0;
    exp_gnt(n + 4, 1'b0, 1'b0, 27'h300, 32'h0, "a_rd_after_full");
    tick(1);
    a_req = 1'b0;
    tick(2);

    // cnet_reprog and n2p_rd_rdy together abort the read, and reprog blocks grants.
    n = cyc;
    cnet_reprog = 1'b1; n2p_rd_rdy = 1'b1; n2p_data = 32'h1111_2222;
    b_req = 1'b1; b_we = 1'b1; b_addr = 27'h240; b_data = 32'hA5A5_0001;
    exp_rd(n + 1, 1'b0, 1'b1, 32'hDEAD_BEEF, "a_rd_reprog_abort");
    tick(1);
    n2p_rd_rdy = 1'b0;
    tick(3);
    cnet_reprog = 1'b0;
    exp_gnt(n + 5, 1'b1, 1'b1, 27'h240, 32'hA5A5_0001, "b_wr_after_reprog");
    tick(1);
    b_req = 1'b0;
    tick(1);

    // B read 0x2000 returning after 10 cycles. A request dropped before IDLE gets no grant.
    n = cyc;
    b_req = 1'b1; b_we = 1'b0; b_addr = 27'h2000; b_data = 32'h0;
    exp_gnt(n + 1, 1'b1, 1'b0, 27'h2000, 32'h0, "b_rd_2000");
    tick(1);
    b_req = 1'b0;
    tick(4);
    a_req = 1'b1; a_we = 1'b1; a_addr = 27'h3F0; a_data = 32'hBAD0_0001;
    tick(3);
    a_req = 1'b0;
    tick(3);
    n2p_rd_rdy = 1'b1; n2p_data = 32'hCAFE_0001;
    exp_rd(n + 12, 1'b1, 1'b0, 32'hCAFE_0001, "b_rd_return");
    tick(1);
    n2p_rd_rdy = 1'b0;
    tick(1);
    n2p_rd_rdy = 1'b1; n2p_data = 32'h0BAD_0BAD;
    tick(1);
    n2p_rd_rdy = 1'b0;
    tick(2);
    chk("rd_data_held", OBS_W'({a_rd_data, b_rd_data}), OBS_W'({32'hDEAD_BEEF, 32'hCAFE_0001}));

    // Reset during an outstanding read: the read is lost, and a later return is dropped.
    n = cyc;
    a_req = 1'b1; a_we = 1'b0; a_addr = 27'h500; a_data = 32'h0;
    exp_gnt(n + 1, 1'b0, 1'b0, 27'h500, 32'h0, "a_rd_before_reset");
    tick(1);
    a_req = 1'b0;
    tick(2);
    reset_n = 1'b0;
    mdl_a_rd = 32'h0; mdl_b_rd = 32'h0;
    tick(1);
    chk("reset_mid_read", obs_s, '0);
    reset_n = 1'b1;
    tick(1);
    n2p_rd_rdy = 1'b1; n2p_data = 32'h1357_9BDF;
    tick(1);
    n2p_rd_rdy = 1'b0;
    tick(2);

    // Simultaneous reads after reset: A first, then B after A's return.
    n = cyc;
    a_req = 1'b1; a_we = 1'b0; a_addr = 27'h10; a_data = 32'h0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 27'h20; b_data = 32'h0;
    exp_gnt(n + 1, 1'b0, 1'b0, 27'h10, 32'h0, "pair_a_first");
    tick(1);
    a_req = 1'b0;
    tick(2);
    n2p_rd_rdy = 1'b1; n2p_data = 32'hA000_0010;
    exp_rd(n + 4, 1'b0, 1'b0, 32'hA000_0010, "pair_a_return");
    exp_gnt(n + 5, 1'b1, 1'b0, 27'h20, 32'h0, "pair_b_after_return");
    tick(1);
    n2p_rd_rdy = 1'b0;
    tick(1);
    b_req = 1'b0;
    tick(1);
    n2p_rd_rdy = 1'b1; n2p_data = 32'hB000_0020;
    exp_rd(n + 7, 1'b1, 1'b0, 32'hB000_0020, "pair_b_return");
    tick(1);
    n2p_rd_rdy = 1'b0;
    // Second pair: the pointer is now on B, so A wins, then B.
    a_req = 1'b1; a_we = 1'b1; a_addr = 27'h11; a_data = 32'h0000_00A1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 27'h21; b_data = 32'h0000_00B1;
    exp_gnt(n + 8, 1'b0, 1'b1, 27'h11, 32'h0000_00A1, "pair2_a");
    exp_gnt(n + 10, 1'b1, 1'b1, 27'h21, 32'h0000_00B1, "pair2_b");
    tick(1);
    a_req = 1'b0;
    tick(2);
    b_req = 1'b0;
    tick(2);

    // Read with no return: times out only when the feature is built in.
    n = cyc;
    a_req = 1'b1; a_we = 1'b0; a_addr = 27'h400; a_data = 32'h0;
    exp_gnt(n + 1, 1'b0, 1'b0, 27'h400, 32'h0, "a_rd_no_return");
    tick(1);
    a_req = 1'b0;
`ifdef CNET_ARB_TIMEOUT_EN
    exp_rd(n + 1 + TMO, 1'b0, 1'b1, 32'hDEAD_BEEF, "a_rd_timeout");
    tick(TMO + 2);
    n2p_rd_rdy = 1'b1; n2p_data = 32'h2468_ACE0;
    tick(1);
    n2p_rd_rdy = 1'b0;
`else
    tick(30);
    n2p_rd_rdy = 1'b1; n2p_data = 32'h2468_ACE0;
    exp_rd(n + 32, 1'b0, 1'b0, 32'h2468_ACE0, "a_rd_late_return");
    tick(1);
    n2p_rd_rdy = 1'b0;
`endif
    tick(4);
    chk("queue_drained", OBS_W'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
